// File: rtl/mem_skew_ctrl.sv
// Skewed read sequencer for a bank of per-row memories feeding a systolic array.
// Lane i reads rows base..base+num_rows-1, starting i cycles after lane 0.
module mem_skew_ctrl #(
  parameter int width_height = 4,
  parameter int addr_w       = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [addr_w-1:0]                base_addr,
  input  logic [addr_w-1:0]                num_rows,
  input  logic                             stall,
  output logic [width_height-1:0]          rd_en,
  output logic [width_height*addr_w-1:0]   rd_addr,
  output logic                             busy,
  output logic                             done,
  output logic [1:0]                       state_dbg
);

  localparam int tw = addr_w + $clog2(width_height) + 1;

  typedef enum logic [1:0] {
    s_idle = 2'd0,
    s_run  = 2'd1,
    s_done = 2'd2
  } state_t;

  state_t                          state, state_n;
  logic [tw-1:0]                   t, t_n;
  logic                            stalled, stalled_n;
  logic [addr_w-1:0]               base_q, base_n;
  logic [addr_w-1:0]               rows_q, rows_n;
  logic [width_height-1:0]         en_n;
  logic [width_height*addr_w-1:0]  addr_n;
  logic                            issue;
  logic [tw-1:0]                   step;
  logic [tw-1:0]                   diff;
  logic [tw-1:0]                   last_step;

  assign state_dbg = state;
  assign last_step = tw'(rows_q) + tw'(width_height) - tw'(2);

  // Outputs are registered, so each edge computes what the following cycle shows.
  // A stall sampled at an edge blanks the next cycle; the pending step is kept in t.
  always_comb begin
    state_n   = state;
    t_n       = t;
    stalled_n = stalled;
    base_n    = base_q;
    rows_n    = rows_q;
    issue     = 1'b0;
    step      = t;
    diff      = '0;
    en_n      = '0;
    addr_n    = rd_addr;

    case (state)
      s_idle: begin
        if (start) begin
          base_n    = base_addr;
          rows_n    = num_rows;
          t_n       = '0;
          stalled_n = 1'b0;
          step      = '0;
          if (num_rows == '0) begin
            state_n = s_done;
          end else begin
            state_n = s_run;
            issue   = 1'b1;
          end
        end
      end
      s_run: begin
        if (!stalled && t == last_step) begin
          state_n   = s_done;
          stalled_n = 1'b0;
        end else begin
          step      = stalled ? t : t + tw'(1);
          t_n       = step;
          stalled_n = stall;
          issue     = !stall;
        end
      end
      s_done: begin
        state_n = s_idle;
      end
      default: begin
        state_n = s_idle;
      end
    endcase

    // Lane i is active while step-i lies in [0, rows); idle lanes hold their address.
    if (issue) begin
      for (int i = 0; i < width_height; i++) begin
        diff = step - tw'(i);
        if (step >= tw'(i) && diff < tw'(rows_n)) begin
          en_n[i]                    = 1'b1;
          addr_n[i*addr_w +: addr_w] = base_n + diff[addr_w-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= s_idle;
      t       <= '0;
      stalled <= 1'b0;
      base_q  <= '0;
      rows_q  <= '0;
      rd_en   <= '0;
      rd_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      t       <= t_n;
      stalled <= stalled_n;
      base_q  <= base_n;
      rows_q  <= rows_n;
      rd_en   <= en_n;
      rd_addr <= addr_n;
      busy    <= (state_n == s_run);
      done    <= (state_n == s_done);
    end
  end

endmodule

// File: doc/mem_skew_ctrl.md
MEM_SKEW_CTRL -- requirements
Module: mem_skew_ctrl

Interface
REQ-001 SHALL have parameter width_height, default 4, number of memory lanes (one 8-bit memory per systolic row).
REQ-002 SHALL have parameter addr_w, default 8, per-lane address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a skewed read burst; sampled only in IDLE.
REQ-006 base_addr  input  addr_w  first row address; latched on accepted start.
REQ-007 num_rows  input  addr_w  rows to read per lane; latched on accepted start.
REQ-008 stall  input  1  downstream back-pressure; freezes sequencing while high.
REQ-009 rd_en  output  width_height  per-lane read enable; bit i drives lane i memory.
REQ-010 rd_addr  output  width_height*addr_w  per-lane read address; lane i at bits [i*addr_w +: addr_w].
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; all outputs registered.
REQ-014 IDLE: start=1 accepted -> latch base_addr, num_rows; clear step counter t to 0; go RUN, or DONE if num_rows=0.
REQ-015 start ignored in RUN and DONE; no queuing.
REQ-016 RUN cycle with step t, stall=0: rd_en[i]=1 iff i <= t < i+num_rows; rd_addr lane i = base+(t-i) mod 2^addr_w when enabled, else held at last value.
REQ-017 Step counter width SHALL hold num_rows+width_height-1 without overflow (addr_w+clog2(width_height)+1 bits).
REQ-018 First RUN cycle (t=0) SHALL be the cycle immediately after the accepting edge: rd_en[0] high one cycle after start sampled.
REQ-019 stall=1 in RUN: all rd_en=0, t held, rd_addr held; sequencing resumes at same t when stall falls.
REQ-020 RUN -> DONE on the edge ending the cycle with t = num_rows+width_height-2 and stall=0.
REQ-021 DONE lasts exactly one cycle: done=1, busy=0, rd_en=0; then IDLE.
REQ-022 busy=1 exactly during RUN cycles, including stalled ones.
REQ-023 Address arithmetic SHALL wrap modulo 2^addr_w with no error indication.
REQ-024 Total rd_en pulses per burst SHALL equal width_height*num_rows; per lane, addresses strictly consecutive (mod 2^addr_w).
REQ-025 stall in IDLE or DONE has no effect.

Reset
REQ-026 reset=1 at rising edge: state IDLE, t=0, rd_en=0, rd_addr=0, busy=0, done=0, latched registers=0.
REQ-027 reset SHALL override every other input, including mid-RUN and during DONE; no done pulse for an aborted burst.
REQ-028 start sampled high on the same edge as reset SHALL be ignored.

Verification (width_height=4, addr_w=8)
REQ-029 start, base=0x10, rows=3, no stall -> rd_en[0] t0-t2 addrs 0x10,0x11,0x12; rd_en[3] t3-t5 addrs 0x10-0x12; busy 6 cycles; done at t6; 12 enables total.
REQ-030 base=0xFE, rows=3 -> every lane reads 0xFE,0xFF,0x00 in order, skewed by lane index.
REQ-031 rows=3 run, stall high for 2 cycles at t=2 -> rd_en all 0 those cycles, busy stays 1, done 2 cycles later than REQ-029, same address sequence.
REQ-032 rows=0 start -> no rd_en, busy never high, done pulse one cycle after accept.
REQ-033 second start during RUN -> ignored, burst unchanged; reset asserted at t=3 -> next cycle all outputs 0, IDLE, no done.
REQ-034 start held high continuously, rows=1 -> bursts back-to-back with one DONE cycle and one IDLE cycle between each.
